// File: rtl/iq_stim_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : iq_stim_gen
// Description : Quadrature tone stimulus generator. A phase accumulator
//               driven by a programmable increment indexes a sine table to
//               produce offset-binary I/Q samples on a divided sample tick,
//               with start-on-nonzero, free-run, DC and frequency-hold modes.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_stim_gen #(
    parameter int IQ_WIDTH      = 5,
    parameter int PHASE_WIDTH   = 16,
    parameter int LUT_ADDR_BITS = 6,
    parameter int AMP           = 10,
    parameter int SAMPLE_DIV    = 1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [2:0]             freq_sel,
    input  logic [PHASE_WIDTH-1:0] base_inc,
    input  logic [PHASE_WIDTH-1:0] step_inc,
    output logic [IQ_WIDTH-1:0]    i_out,
    output logic [IQ_WIDTH-1:0]    q_out,
    output logic                   valid,
    output logic                   started,
    output logic [COUNT_WIDTH-1:0] sample_count
);

    localparam logic [1:0] c_mode_start = 2'd0;
    localparam logic [1:0] c_mode_free  = 2'd1;
    localparam logic [1:0] c_mode_dc    = 2'd2;
    localparam logic [1:0] c_mode_hold  = 2'd3;

    localparam int c_lut_size = 1 << LUT_ADDR_BITS;
    localparam int c_quarter  = c_lut_size / 4;
    localparam int c_mid_int  = 1 << (IQ_WIDTH - 1);
    localparam int c_div_w    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [IQ_WIDTH-1:0]      c_mid      = IQ_WIDTH'(c_mid_int);
    localparam logic [c_div_w-1:0]       c_div_last = c_div_w'(SAMPLE_DIV - 1);
    localparam logic [LUT_ADDR_BITS-1:0] c_q_offset = LUT_ADDR_BITS'(c_quarter);
    // pi in Q30 fixed point, used only while building the table
    localparam longint c_pi_q30 = 64'sd3373259426;

    // Elaboration-time sine entry: round(AMP*sin(2*pi*k/N)), half away from
    // zero. Evaluated on the first quadrant by Taylor series in Q30 and
    // mirrored into the other three so the table is exactly symmetric.
    function automatic int sin_entry(input int k);
        int     quad;
        int     m;
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint scaled;
        quad = (k / c_quarter) % 4;
        m    = k % c_quarter;
        if (quad == 1 || quad == 3) m = c_quarter - m;
        x    = (2 * c_pi_q30 * longint'(m)) / longint'(c_lut_size);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        scaled = (longint'(AMP) * acc + (64'sd1 <<< 29)) >>> 30;
        if (quad >= 2) scaled = -scaled;
        return int'(scaled);
    endfunction

    logic [IQ_WIDTH-1:0] w_lut [c_lut_size];

    for (genvar g = 0; g < c_lut_size; g++) begin : g_lut
        localparam int c_entry = sin_entry(g);
        assign w_lut[g] = IQ_WIDTH'(c_mid_int + c_entry);
    end

    logic [c_div_w-1:0]       r_div;
    logic [PHASE_WIDTH-1:0]   r_phase;
    logic [PHASE_WIDTH-1:0]   r_hold;
    logic                     r_started;
    logic                     r_valid;
    logic [IQ_WIDTH-1:0]      r_i;
    logic [IQ_WIDTH-1:0]      r_q;
    logic [COUNT_WIDTH-1:0]   r_count;

    logic                     w_tick;
    logic [PHASE_WIDTH-1:0]   w_inc_live;
    logic [PHASE_WIDTH-1:0]   w_inc;
    logic [PHASE_WIDTH-1:0]   w_phase_next;
    logic [LUT_ADDR_BITS-1:0] w_addr_i;
    logic [LUT_ADDR_BITS-1:0] w_addr_q;
    logic                     w_start_ok;
    logic                     w_fire;

    assign w_tick       = enable && (r_div == c_div_last);
    assign w_inc_live   = base_inc + PHASE_WIDTH'(freq_sel) * step_inc;
    assign w_inc        = (mode == c_mode_hold) ? r_hold : w_inc_live;
    assign w_phase_next = r_phase + w_inc;
    assign w_addr_i     = w_phase_next[PHASE_WIDTH-1 -: LUT_ADDR_BITS];
    assign w_addr_q     = w_addr_i + c_q_offset;
    // start-on-nonzero waits for a nonzero code; free-run and hold start at once
    assign w_start_ok   = (mode == c_mode_start) ? (freq_sel != 3'd0)
                                                 : (mode == c_mode_free || mode == c_mode_hold);
    // a sample is emitted on every tick in DC mode, otherwise only once started
    assign w_fire       = w_tick && ((mode == c_mode_dc) || r_started);

    // Sample-rate divider: counts enabled clocks, wraps after the tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (!enable || r_div == c_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    // Start control, phase accumulation and registered I/Q sample outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase   <= '0;
            r_hold    <= '0;
            r_started <= 1'b0;
            r_valid   <= 1'b0;
            r_i       <= c_mid;
            r_q       <= c_mid;
        end else if (!enable) begin
            r_phase   <= '0;
            r_started <= 1'b0;
            r_valid   <= 1'b0;
            r_i       <= c_mid;
            r_q       <= c_mid;
        end else begin
            r_valid <= 1'b0;
            if (w_tick) begin
                if (mode == c_mode_dc) begin
                    r_i     <= c_mid;
                    r_q     <= c_mid;
                    r_valid <= 1'b1;
                end else if (r_started) begin
                    r_phase <= w_phase_next;
                    r_i     <= w_lut[w_addr_i];
                    r_q     <= w_lut[w_addr_q];
                    r_valid <= 1'b1;
                end else if (w_start_ok) begin
                    // the start tick only arms the generator; it captures the
                    // increment used by frequency-hold mode
                    r_started <= 1'b1;
                    r_hold    <= w_inc_live;
                end
            end
        end
    end

    // Saturating count of emitted samples, unaffected by enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_fire && (r_count != {COUNT_WIDTH{1'b1}})) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign i_out        = r_i;
    assign q_out        = r_q;
    assign valid        = r_valid;
    assign started      = r_started;
    assign sample_count = r_count;

endmodule
`default_nettype wire

// File: doc/iq_stim_gen.md
IQ_STIM_GEN -- requirements
Module: iq_stim_gen

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 5, I/Q sample width (unsigned, offset-binary).
REQ-002 SHALL have parameter PHASE_WIDTH, default 16, phase accumulator width.
REQ-003 SHALL have parameter LUT_ADDR_BITS, default 6, sine table address width (2^LUT_ADDR_BITS entries per full cycle).
REQ-004 SHALL have parameter AMP, default 10, tone amplitude in LSBs; legal range 1 to 2^(IQ_WIDTH-1)-1.
REQ-005 SHALL have parameter SAMPLE_DIV, default 1, clocks per sample tick (>=1).
REQ-006 SHALL have parameter COUNT_WIDTH, default 16, sample counter width.
REQ-007 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port enable  input  1  run gate.
REQ-010 SHALL have port mode  input  2  0=start-on-nonzero, 1=free-run, 2=DC, 3=frequency-hold.
REQ-011 SHALL have port freq_sel  input  3  modulator frequency code.
REQ-012 SHALL have port base_inc  input  PHASE_WIDTH  phase increment for freq_sel=0.
REQ-013 SHALL have port step_inc  input  PHASE_WIDTH  increment added per freq_sel LSB.
REQ-014 SHALL have port i_out  output  IQ_WIDTH  in-phase sample.
REQ-015 SHALL have port q_out  output  IQ_WIDTH  quadrature sample.
REQ-016 SHALL have port valid  output  1  one-clock pulse when i_out/q_out carry a new sample.
REQ-017 SHALL have port started  output  1  tone generation active.
REQ-018 SHALL have port sample_count  output  COUNT_WIDTH  number of valid pulses, saturating.

Function
REQ-019 Divider SHALL count 0..SAMPLE_DIV-1 while enable=1; tick asserts in the cycle the count is SAMPLE_DIV-1, then wraps to 0; SAMPLE_DIV=1 gives a tick every enabled clock.
REQ-020 Increment SHALL be inc = base_inc + freq_sel*step_inc, truncated modulo 2^PHASE_WIDTH.
REQ-021 On a tick with started=1 and mode!=2, phase SHALL become phase+inc modulo 2^PHASE_WIDTH (wrap silently).
REQ-022 LUT address SHALL be the top LUT_ADDR_BITS of the updated phase; entry k = round(AMP*sin(2*pi*k/2^LUT_ADDR_BITS)), round half away from zero.
REQ-023 Same edge as REQ-021: i_out <= MID+sin(addr), q_out <= MID+sin(addr+2^(LUT_ADDR_BITS-2)), MID=2^(IQ_WIDTH-1); valid=1 that cycle only (zero added latency after tick).
REQ-024 Mode 0: started sets on the first tick where freq_sel!=0; that tick does not advance phase or pulse valid; advancement begins on the next tick.
REQ-025 Mode 1: started sets on the first tick after enable=1, without advancing; advancement begins on the next tick.
REQ-026 Mode 3: as mode 1, but inc is captured into a hold register on the start tick and freq_sel/base_inc/step_inc are ignored thereafter until started clears.
REQ-027 Mode 2: i_out=q_out=MID, phase held, valid pulses on every tick regardless of started.
REQ-028 Before started (modes 0/1/3): i_out=q_out=MID, phase=0, valid=0.
REQ-029 enable=0 SHALL synchronously clear divider, phase, started, and set i_out=q_out=MID, valid=0; sample_count held.
REQ-030 Mode change while started SHALL take effect at the next tick; phase is not reset; changing into mode 0 or 1 keeps started=1.
REQ-031 sample_count SHALL increment on each valid pulse and hold at 2^COUNT_WIDTH-1.

Reset
REQ-032 reset=1 SHALL immediately, regardless of clock, force phase=0, divider=0, hold register=0, started=0, valid=0, sample_count=0, i_out=q_out=MID.
REQ-033 After reset release the first tick SHALL occur SAMPLE_DIV enabled clocks later.

Verification
REQ-034 Mode 0, enable=1, freq_sel=0 for 10 ticks -> started=0, valid never asserts, i_out=q_out=16; then freq_sel=1 -> started=1 after that tick, first valid on the following tick.
REQ-035 Mode 1, base_inc=0x4000, step_inc=0 -> successive valid samples phase 0x4000,0x8000,0xC000,0x0000; i_out 26,16,6,16; q_out 16,6,16,26.
REQ-036 SAMPLE_DIV=4, mode 1 -> valid exactly every 4th clock; mode 2 -> i_out=q_out=16 with valid every 4th clock.
REQ-037 Mode 3, base_inc=0x1000, step_inc=0x0100, freq_sel=2 at start then 7 -> phase steps stay 0x1200 per tick.
REQ-038 COUNT_WIDTH=4, 20 valid pulses -> sample_count reaches 15 and holds.
REQ-039 reset asserted mid-clock-period while started -> all outputs at reset values before the next clock edge; restart follows REQ-024/REQ-025 from phase 0.
